// File: rtl/lvds_rx_pkg.sv
// Shared types and constants for the LVDS frame receiver.
// Holds the receiver FSM state enum and the default sync pattern.
package lvds_rx_pkg;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_REC  = 1'b1
    } rx_state_e;

    localparam logic [31:0] SYNC_DEFAULT = 32'h5346444B;

endpackage

// File: rtl/lvds_sync_fifo.sv
// Single-clock first-word-fall-through FIFO, async active-low reset.
// Ports: clk, rst_n, i_push/i_data, i_pop, o_data, o_empty, o_full, o_level.
module lvds_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_MAX);
    assign o_level = r_count;

    assign w_pop  = i_pop && !o_empty;
    // A full FIFO still takes a word when a slot frees on this edge.
    assign w_push = i_push && (!o_full || w_pop);

    // Gated so the read port shows zero whenever nothing is held.
    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lvds_frame_rx.sv
// Serial LVDS frame receiver: hunts a sync word, then deframes payload words.
// Ports: lvds_clk, rst_n, lvds_data_in, enable, out_* stream, frame_cnt, overflow, fifo_level.
module lvds_frame_rx
    import lvds_rx_pkg::*;
#(
    parameter int              DATA_W     = 32,
    parameter int              NUM_WORDS  = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(SYNC_DEFAULT),
    parameter int              FIFO_DEPTH = 16,
    parameter bit              MSB_FIRST  = 1'b1
) (
    input  logic                          lvds_clk,
    input  logic                          rst_n,
    input  logic                          lvds_data_in,
    input  logic                          enable,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last,
    output logic [15:0]                   frame_cnt,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BW = $clog2(DATA_W);
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [WW-1:0] WORD_ONE  = WW'(1);

    rx_state_e        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BW-1:0]    r_bit_cnt;
    logic [WW-1:0]    r_word_cnt;
    logic [15:0]      r_frame_cnt;
    logic             r_overflow;
    logic             r_armed;

    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_bit_last;
    logic              w_last_word;
    logic              w_word_done;
    logic              w_sync_hit;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf_set;
    logic [DATA_W:0]   w_fifo_rd;

    always_comb begin
        if (MSB_FIRST) begin
            w_shift_nxt = {r_shift[DATA_W-2:0], lvds_data_in};
        end else begin
            w_shift_nxt = {lvds_data_in, r_shift[DATA_W-1:1]};
        end
    end

    assign w_bit_last  = (r_state == ST_REC) && (r_bit_cnt == BIT_LAST);
    assign w_last_word = (r_word_cnt == WORD_LAST);
    assign w_word_done = enable && w_bit_last;

    // r_armed blocks any match on the first edge after reset release.
    assign w_sync_hit = (r_state == ST_HUNT) && enable && r_armed
                     && (w_shift_nxt == SYNC_WORD);

    assign w_pop     = out_valid && out_ready;
    assign w_ovf_set = w_word_done && w_full && !w_pop;

    always_ff @(posedge lvds_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HUNT;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_frame_cnt <= '0;
            r_overflow  <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_shift <= w_shift_nxt;
            r_armed <= 1'b1;
            if (!enable) begin
                r_state    <= ST_HUNT;
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
            end else begin
                unique case (r_state)
                    ST_HUNT: begin
                        if (w_sync_hit) begin
                            r_state    <= ST_REC;
                            r_bit_cnt  <= '0;
                            r_word_cnt <= '0;
                        end
                    end
                    ST_REC: begin
                        if (w_bit_last) begin
                            r_bit_cnt <= '0;
                            if (w_last_word) begin
                                r_word_cnt  <= '0;
                                r_state     <= ST_HUNT;
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                            end else begin
                                r_word_cnt <= r_word_cnt + WORD_ONE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_ONE;
                        end
                    end
                endcase
            end
            // Setting beats clearing on a coincident edge.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    lvds_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (lvds_clk),
        .rst_n   (rst_n),
        .i_push  (w_word_done),
        .i_data  ({w_last_word, w_shift_nxt}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rd),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (fifo_level)
    );

    assign out_valid = !w_empty;
    assign out_data  = w_fifo_rd[DATA_W-1:0];
    assign out_last  = w_fifo_rd[DATA_W];
    assign frame_cnt = r_frame_cnt;
    assign overflow  = r_overflow;

endmodule
